// File: rtl/dlock_pkg.sv
// Shared types for the dlock key driver: command codes, FSM states, key count.
package dlock_pkg;

  localparam int KEY_NUM = 10;

  typedef enum logic [1:0] {
    CMD_DIGITS = 2'd0,
    CMD_OPEN   = 2'd1,
    CMD_SET    = 2'd2,
    CMD_CLOSE  = 2'd3
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_KEY_HOLD = 3'd1,
    S_KEY_GAP  = 3'd2,
    S_BTN_HOLD = 3'd3,
    S_BTN_GAP  = 3'd4,
    S_FINISH   = 3'd5
  } state_t;

endpackage

// File: rtl/dlock_bcd_onehot.sv
// BCD nibble to one-hot key decoder with a digit-valid flag; purely combinational.
// Latency 0, no flow control; out-of-range nibbles give an all-zero one-hot.
module dlock_bcd_onehot
  import dlock_pkg::*;
(
  input  logic [3:0]         bcd,
  output logic [KEY_NUM-1:0] onehot,
  output logic               valid
);

  always_comb begin
    valid = (bcd < 4'd10);
    for (int i = 0; i < KEY_NUM; i++) begin
      onehot[i] = (bcd == 4'(i));
    end
  end

endmodule

// File: rtl/dlock_key_driver.sv
// Plays a BCD code plus OPEN/SET/CLOSE onto the dlock inputs as timed press/release pulses.
// First press line 1 cycle after START; START ignored (not queued) while a sequence runs.
module dlock_key_driver
  import dlock_pkg::*;
#(
  parameter int NDIG        = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                START,
  input  logic [1:0]          CMD,
  input  logic [4*NDIG-1:0]   CODE,
  output logic                BUSY,
  output logic                DONE,
  output logic                ERR,
  output logic [KEY_NUM-1:0]  KEY,
  output logic                OPEN,
  output logic                SET,
  output logic                CLOSE
);

  localparam int TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int IW   = $clog2(NDIG + 1);

  state_t              state;
  cmd_t                cmd_q;
  logic [4*NDIG-1:0]   code_q;
  logic [TW-1:0]       tmr;
  logic [IW-1:0]       idx;

  logic [4*NDIG-1:0]   src;
  logic [KEY_NUM-1:0]  oh [NDIG];
  logic [NDIG-1:0]     ok;
  logic                ok_all;
  logic [IW-1:0]       nxt_idx;
  logic [KEY_NUM-1:0]  next_oh;
  logic                hold_end;
  logic                gap_end;

  // In IDLE the decoders look at the live CODE for validation; afterwards at the latched copy.
  assign src = (state == S_IDLE) ? CODE : code_q;

  // Digit d is the d-th nibble sent, counted from the most-significant end.
  for (genvar d = 0; d < NDIG; d++) begin : g_dec
    dlock_bcd_onehot u_dec (
      .bcd    (src[4*(NDIG-1-d) +: 4]),
      .onehot (oh[d]),
      .valid  (ok[d])
    );
  end

  assign ok_all   = &ok;
  assign nxt_idx  = (state == S_IDLE) ? '0 : idx + IW'(1);
  assign hold_end = (tmr == TW'(HOLD_CYCLES - 1));
  assign gap_end  = (tmr == TW'(GAP_CYCLES - 1));

  always_comb begin
    next_oh = '0;
    for (int d = 0; d < NDIG; d++) begin
      if (nxt_idx == IW'(d)) next_oh = oh[d];
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= S_IDLE;
      cmd_q  <= CMD_DIGITS;
      code_q <= '0;
      tmr    <= '0;
      idx    <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      ERR    <= 1'b0;
      KEY    <= '0;
      OPEN   <= 1'b0;
      SET    <= 1'b0;
      CLOSE  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      ERR  <= 1'b0;
      case (state)
        S_IDLE: begin
          tmr <= '0;
          idx <= '0;
          if (START) begin
            code_q <= CODE;
            cmd_q  <= cmd_t'(CMD);
            if (!ok_all) begin
              ERR <= 1'b1;
            end else begin
              BUSY <= 1'b1;
              if (cmd_t'(CMD) == CMD_CLOSE) begin
                state <= S_BTN_HOLD;
                CLOSE <= 1'b1;
              end else begin
                state <= S_KEY_HOLD;
                KEY   <= next_oh;
              end
            end
          end
        end
        S_KEY_HOLD: begin
          if (hold_end) begin
            state <= S_KEY_GAP;
            tmr   <= '0;
            KEY   <= '0;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        S_KEY_GAP: begin
          if (gap_end) begin
            tmr <= '0;
            if (idx != IW'(NDIG - 1)) begin
              idx   <= nxt_idx;
              state <= S_KEY_HOLD;
              KEY   <= next_oh;
            end else if (cmd_q == CMD_DIGITS) begin
              state <= S_FINISH;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
            end else begin
              state <= S_BTN_HOLD;
              OPEN  <= (cmd_q == CMD_OPEN);
              SET   <= (cmd_q == CMD_SET);
            end
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        S_BTN_HOLD: begin
          if (hold_end) begin
            state <= S_BTN_GAP;
            tmr   <= '0;
            OPEN  <= 1'b0;
            SET   <= 1'b0;
            CLOSE <= 1'b0;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        S_BTN_GAP: begin
          if (gap_end) begin
            state <= S_FINISH;
            tmr   <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dlock_key_driver.sv
// Bench for dlock_key_driver: table vectors, directed reset/busy cases, random runs vs a press-list model.
module tb_dlock_key_driver;

  localparam int NDIG = 2;
  localparam int HOLD = 4;
  localparam int GAP  = 4;
  localparam int PER  = HOLD + GAP;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] cmd = 2'd0;
  logic [7:0] code = 8'h00;
  logic       busy, done, err, open_b, set_b, close_b;
  logic [9:0] key;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dlock_key_driver #(.NDIG(NDIG), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
    .CLK(clk), .RESET_N(rst_n), .START(start), .CMD(cmd), .CODE(code),
    .BUSY(busy), .DONE(done), .ERR(err), .KEY(key),
    .OPEN(open_b), .SET(set_b), .CLOSE(close_b)
  );

  // Bit layout: {BUSY, DONE, ERR, KEY[9:0], OPEN, SET, CLOSE}
  function automatic logic [15:0] outs();
    return {busy, done, err, key, open_b, set_b, close_b};
  endfunction

  function automatic bit code_ok(logic [7:0] cd);
    for (int d = 0; d < NDIG; d++) if (cd[4*d +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int npress(logic [1:0] c);
    if (c == 2'd3) return 1;
    if (c == 2'd0) return NDIG;
    return NDIG + 1;
  endfunction

  // Expected outputs in cycle k after the START sample edge, built from the list of presses.
  function automatic logic [15:0] model(int k, logic [1:0] c, logic [7:0] cd);
    logic [12:0] pr [NDIG+1];
    logic [15:0] e;
    int np, p, off;
    e = '0;
    if (!code_ok(cd)) begin
      if (k == 1) e[13] = 1'b1;
      return e;
    end
    np = 0;
    if (c != 2'd3) begin
      for (int d = 0; d < NDIG; d++) begin
        pr[np] = 13'(1) << (3 + int'(cd[4*(NDIG-1-d) +: 4]));
        np++;
      end
    end
    if (c == 2'd1) begin pr[np] = 13'h0004; np++; end
    if (c == 2'd2) begin pr[np] = 13'h0002; np++; end
    if (c == 2'd3) begin pr[np] = 13'h0001; np++; end
    if (k >= 1 && k <= np*PER) begin
      e[15] = 1'b1;
      p   = (k - 1) / PER;
      off = (k - 1) % PER;
      if (off < HOLD) e[12:0] = pr[p];
    end
    if (k == np*PER + 1) e[14] = 1'b1;
    return e;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Issues one request and checks every cycle up to DONE (or a few cycles after a rejection).
  task automatic run_seq(input logic [1:0] c, input logic [7:0] cd, input bit noise,
                         input int inj, input string tag,
                         output int done_cyc, output logic [12:0] first_line);
    int p, len;
    bit ok;
    logic [15:0] o;
    ok = code_ok(cd);
    p = npress(c);
    len = ok ? p*PER + 1 : 3;
    done_cyc = 0;
    first_line = '0;
    @(negedge clk);
    start = 1'b1; cmd = c; code = cd;
    @(posedge clk);
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      o = outs();
      chk($sformatf("%s cyc%0d", tag, k), o, model(k, c, cd));
      if (k == 1) first_line = o[12:0];
      if (o[14] && done_cyc == 0) done_cyc = k;
      start = 1'b0;
      if (ok && k < p*PER) begin
        if (k == inj) begin
          start = 1'b1; cmd = 2'd0; code = 8'h11;
        end else if (noise && $urandom_range(0, 3) == 0) begin
          start = 1'b1; cmd = 2'($urandom); code = 8'($urandom);
        end
      end
    end
  endtask

  typedef struct {
    logic [1:0]  cmd;
    logic [7:0]  code;
    int          done_cyc;
    logic [12:0] first_line;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs [7];
    int dc;
    logic [12:0] fl;
    logic [1:0] rc;
    logic [7:0] rcd;

    vecs[0] = '{2'd1, 8'h00, 25, 13'h0008};
    vecs[1] = '{2'd2, 8'h25, 25, 13'h0020};
    vecs[2] = '{2'd3, 8'h00,  9, 13'h0001};
    vecs[3] = '{2'd0, 8'h93, 17, 13'h1000};
    vecs[4] = '{2'd1, 8'h7A,  0, 13'h0000};
    vecs[5] = '{2'd2, 8'hA0,  0, 13'h0000};
    vecs[6] = '{2'd3, 8'hFF,  0, 13'h0000};

    // Reset held with START high: nothing may move.
    start = 1'b1; cmd = 2'd3; code = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("reset cyc%0d", i), outs(), 16'h0000);
    end
    rst_n = 1'b1; start = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_seq(vecs[i].cmd, vecs[i].code, 1'b0, -1, $sformatf("vec%0d", i), dc, fl);
      chk_int($sformatf("vec%0d done_cycle", i), dc, vecs[i].done_cyc);
      chk($sformatf("vec%0d first_line", i), {3'b000, fl}, {3'b000, vecs[i].first_line});
    end

    // START during a running sequence is neither taken nor queued.
    run_seq(2'd2, 8'h25, 1'b0, 6, "busy_start", dc, fl);
    chk_int("busy_start done_cycle", dc, 25);

    // Reset mid-press drops KEY without a clock edge.
    @(negedge clk);
    start = 1'b1; cmd = 2'd1; code = 8'h00;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("midreset press", outs(), 16'h8008);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midreset async", outs(), 16'h0000);
    @(negedge clk);
    chk("midreset held", outs(), 16'h0000);
    rst_n = 1'b1;
    run_seq(2'd3, 8'h00, 1'b0, -1, "after_reset", dc, fl);
    chk_int("after_reset done_cycle", dc, 9);

    for (int r = 0; r < 40; r++) begin
      rc = 2'($urandom);
      for (int d = 0; d < NDIG; d++) begin
        if ($urandom_range(0, 7) == 0) rcd[4*d +: 4] = 4'($urandom_range(10, 15));
        else                           rcd[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      run_seq(rc, rcd, 1'($urandom_range(0, 1)), -1, $sformatf("rand%0d", r), dc, fl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
